track_para_rd_sched: RTL

- Schedules DDR burst reads of per-track parameter blocks and streams each block as 32-bit words to the track parameter consumer.
- Arbitrates two fetch requesters: zero-flag reload of the current track, and new-track load.
- Issues one 16-beat x 256-bit burst per block (= 128 x 32-bit words), buffers the returned beats and serializes them under consumer read-enable.
- Sits between the DDR read port and the track parameter controller; generates that controller's burst_end / vld / data inputs.

---
 rtl/track_para_rd_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/track_para_rd_sched.sv
// Track parameter read scheduler: DDR burst fetch of per-track blocks,
// serialized to 32-bit words. Optional watchdog: TRACK_PARA_TIMEOUT_EN.
module track_para_rd_sched #(
  parameter real               TCQ            = 0.1,
  parameter int                ADDR_W         = 30,
  parameter logic [ADDR_W-1:0] PARA_BASE_ADDR = 30'h0100_0000,
  parameter int                BLOCK_BYTES    = 512,
  parameter int                BURST_LEN      = 16,
  parameter int                TRACK_W        = 10,
  parameter int                TIMEOUT_CYC    = 4096
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              reload_req_i,
  input  logic              track_req_i,
  input  logic [TRACK_W-1:0] track_idx_i,
  output logic              busy_o,
  output logic              ddr_cmd_vld_o,
  output logic [ADDR_W-1:0] ddr_cmd_addr_o,
  input  logic              ddr_cmd_rdy_i,
  input  logic              ddr_rdata_vld_i,
  input  logic [255:0]      ddr_rdata_i,
  output logic              ddr_rdata_rdy_o,
  output logic              para_burst_end_o,
  input  logic              para_ren_i,
  output logic              para_vld_o,
  output logic [31:0]       para_data_o,
  output logic              fetch_done_o,
  output logic              fetch_err_o
);

  localparam int WORDS  = BURST_LEN * 8;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int WORD_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic               pend_rld_q;
  logic               pend_trk_q;
  logic [TRACK_W-1:0] pend_idx_q;
  logic [TRACK_W-1:0] cur_track_q;
  logic               grant_rld;
  logic               grant_trk;

  logic [255:0]       buf_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         cnt_q;
  logic [BEAT_W-1:0]  beat_cnt_q;
  logic [2:0]         wsel_q;
  logic [WORD_W-1:0]  word_cnt_q;
  logic               burst_end_q;

  logic [ADDR_W-1:0]  blk_addr;
  logic               cmd_hs;
  logic               beat_acc;
  logic               emit;
  logic               pop;
  logic               last_word;
  logic               tmo;

  assign blk_addr = PARA_BASE_ADDR
                  + (ADDR_W'(cur_track_q) * ADDR_W'(BLOCK_BYTES));

  assign cmd_hs    = (state_q == S_CMD) && ddr_cmd_rdy_i;
  assign beat_acc  = ddr_rdata_vld_i && ddr_rdata_rdy_o;
  assign emit      = (state_q == S_STREAM) && para_ren_i
                   && (cnt_q != 2'd0);
  assign pop       = emit && (wsel_q == 3'd7);
  assign last_word = emit && (word_cnt_q == WORD_W'(WORDS - 1));

  assign busy_o           = (state_q != S_IDLE);
  assign ddr_cmd_vld_o    = (state_q == S_CMD);
  assign ddr_cmd_addr_o   = (state_q == S_CMD) ? blk_addr : '0;
  assign ddr_rdata_rdy_o  = (state_q == S_STREAM) && (cnt_q != 2'd2)
                          && (beat_cnt_q < BEAT_W'(BURST_LEN));
  assign para_burst_end_o = burst_end_q;
  assign fetch_done_o     = (state_q == S_DONE);

`ifdef TRACK_PARA_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            wd_live;

  assign wd_live = (state_q == S_CMD) || (state_q == S_STREAM);
  assign tmo     = wd_live && !cmd_hs && !beat_acc
                 && (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign fetch_err_o = err_q;

  // Watchdog: cycles without handshake progress; error is sticky
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (tmo) err_q <= 1'b1;
      if (!wd_live || cmd_hs || beat_acc || tmo) wd_q <= '0;
      else wd_q <= wd_q + 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  // Next state and arbitration; reload beats new-track
  always_comb begin
    state_d   = state_q;
    grant_rld = 1'b0;
    grant_trk = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_rld_q) begin
          grant_rld = 1'b1;
          state_d   = S_CMD;
        end else if (pend_trk_q) begin
          grant_trk = 1'b1;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (tmo) state_d = S_IDLE;
        else if (ddr_cmd_rdy_i) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (tmo) state_d = S_IDLE;
        else if (last_word) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pending requests; a fresh request outranks a same-cycle grant
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_rld_q  <= 1'b0;
      pend_trk_q  <= 1'b0;
      pend_idx_q  <= '0;
      cur_track_q <= '0;
    end else begin
      if (reload_req_i) pend_rld_q <= 1'b1;
      else if (grant_rld) pend_rld_q <= 1'b0;
      if (track_req_i) begin
        pend_trk_q <= 1'b1;
        pend_idx_q <= track_idx_i;
      end else if (grant_trk) begin
        pend_trk_q <= 1'b0;
      end
      if (grant_trk) cur_track_q <= pend_idx_q;
    end
  end

  // Beat buffer and word serializer; cleared at each new burst
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      beat_cnt_q  <= '0;
      wsel_q      <= '0;
      word_cnt_q  <= '0;
      para_vld_o  <= 1'b0;
      para_data_o <= '0;
      burst_end_q <= 1'b0;
    end else begin
      burst_end_q <= cmd_hs;
      para_vld_o  <= emit && !tmo;
      if (cmd_hs || tmo) begin
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
        cnt_q      <= '0;
        beat_cnt_q <= '0;
        wsel_q     <= '0;
        word_cnt_q <= '0;
      end else begin
        if (beat_acc) begin
          buf_q[wr_ptr_q] <= ddr_rdata_i;
          wr_ptr_q        <= ~wr_ptr_q;
          beat_cnt_q      <= beat_cnt_q + 1'b1;
        end
        if (emit) begin
          para_data_o <= buf_q[rd_ptr_q][{wsel_q, 5'd0} +: 32];
          wsel_q      <= wsel_q + 1'b1;
          word_cnt_q  <= word_cnt_q + 1'b1;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        cnt_q <= cnt_q + 2'(beat_acc) - 2'(pop);
      end
    end
  end

endmodule
